mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1: cycles from issue to memory read data valid (range 1..7).
REQ-002 SHALL have parameter MAX_STREAK, default 4: consecutive contested data grants before fetch is forced (range 1..15).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_req  in  1  fetch request, level, held until if_gnt.
REQ-006 SHALL have port if_addr  in  32  fetch byte address.
REQ-007 SHALL have port if_gnt  out  1  fetch issue pulse.
REQ-008 SHALL have port if_rvalid  out  1  fetch data valid pulse.
REQ-009 SHALL have port if_rdata  out  32  fetch read data.
REQ-010 SHALL have port d_req  in  1  data request, level, held until d_gnt.
REQ-011 SHALL have port d_we  in  1  data write enable (1 = store).
REQ-012 SHALL have port d_addr  in  32  data byte address.
REQ-013 SHALL have port d_wdata  in  32  store data.
REQ-014 SHALL have port d_gnt  out  1  data issue pulse.
REQ-015 SHALL have port d_rvalid  out  1  load data / store completion pulse.
REQ-016 SHALL have port d_rdata  out  32  load data (0 for stores).
REQ-017 SHALL have ports mem_enable, mem_wr (out 1), mem_addr, mem_data_in (out 32), mem_data_out (in 32) to one shared memory2c port.
REQ-018 SHALL have port busy  out  1  transaction outstanding.

Function
REQ-019 SHALL implement FSM IDLE, WAIT; one outstanding transaction maximum.
REQ-020 In IDLE with any request, SHALL issue exactly one: mem_enable=1, mem_addr/mem_wr/mem_data_in from winner, winner gnt=1, same cycle (combinational), then go to WAIT.
REQ-021 Outside an issue cycle, mem_enable, mem_wr, mem_addr, mem_data_in, if_gnt, d_gnt SHALL be 0.
REQ-022 Fetch issues SHALL drive mem_wr=0 and mem_data_in=0.
REQ-023 Arbitration: only one requester wins it; both requesting wins data, unless streak==MAX_STREAK, then fetch.
REQ-024 4-bit streak SHALL increment on a data grant with if_req=1, clear on fetch grant, clear when if_req=0 in IDLE, saturate at MAX_STREAK.
REQ-025 WAIT SHALL count MEM_LAT cycles; on the last, capture mem_data_out into the issuing requester's rdata register and pulse its rvalid next cycle, returning to IDLE in that cycle.
REQ-026 A store SHALL pulse d_rvalid at the same latency as a load, d_rdata=0.
REQ-027 rdata registers SHALL hold until the next capture for that requester.
REQ-028 Issue SHALL be allowed in the rvalid cycle (IDLE); throughput = 1 transaction per MEM_LAT+1 cycles.
REQ-029 busy SHALL be 1 in WAIT and during the rvalid cycle's preceding capture, 0 in IDLE.
REQ-030 Request changes while waiting for grant SHALL be ignored until IDLE samples them.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, streak=0, all outputs 0, rdata registers 0.
REQ-032 Reset mid-WAIT SHALL abort the transaction; no rvalid SHALL be produced for it after release.

Structure
REQ-033 State enum, MEM_LAT/MAX_STREAK defaults and streak width SHALL reside in shared package riscv_arb_pkg.
REQ-034 Grant selection and streak counter SHALL be one sub-module, mem_arbiter_prio; FSM, latency counter, and data capture stay in mem_arbiter.

Verification
REQ-035 Fetch only, if_addr=0x10, memory word 0x00500093, MEM_LAT=1 -> if_gnt cycle 0, if_rvalid cycle 2 with if_rdata=0x00500093.
REQ-036 d_req store 0xDEADBEEF to 0x100, then load 0x100 -> mem_wr=1 once; load d_rdata=0xDEADBEEF; store d_rdata=0.
REQ-037 if_req and d_req held continuously, MAX_STREAK=4 -> grant sequence D,D,D,D,F,D,D,D,D,F.
REQ-038 MEM_LAT=3, back-to-back fetches -> issues at cycles 0,4,8; rvalid at 4,8,12.
REQ-039 rst low in WAIT cycle 1 of a load -> outputs 0 asynchronously; no d_rvalid after release; next request serviced normally.
REQ-040 Both requesters with if_req dropped before streak saturates -> streak clears; later contest grants data first.

Source files
------------

// File: rtl/riscv_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Both requesters share a single memory port and are selected by a streak-limited priority scheme.
package riscv_arb_pkg;

    localparam int MEM_LAT_DEF    = 1;
    localparam int MAX_STREAK_DEF = 4;
    localparam int STREAK_W       = 4;
    localparam int LAT_W          = 3;

    // Requester slots; index order is used by the capture registers
    localparam int N_REQ  = 2;
    localparam int REQ_IF = 0;
    localparam int REQ_D  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    function automatic logic [STREAK_W-1:0] streak_inc(
        input logic [STREAK_W-1:0] cur,
        input logic [STREAK_W-1:0] cap
    );
        return (cur >= cap) ? cap : cur + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter_prio.sv
// Grant selection between fetch and data with a streak counter.
// Data normally wins; fetch is forced once data has won MAX_STREAK contested grants in a row.
module mem_arbiter_prio
    import riscv_arb_pkg::*;
#(
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_gnt_if,
    output logic o_gnt_d
);

    localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] r_streak;
    logic                w_force_if;

    always_comb begin
        w_force_if = i_if_req && i_d_req && (r_streak == STREAK_CAP);
        o_gnt_if   = 1'b0;
        o_gnt_d    = 1'b0;
        if (i_idle) begin
            if (i_d_req && !w_force_if) begin
                o_gnt_d = 1'b1;
            end else if (i_if_req) begin
                o_gnt_if = 1'b1;
            end
        end
    end

    // Only a data grant that actually starved a waiting fetch extends the streak
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (i_idle) begin
            if (o_gnt_if || !i_if_req) begin
                r_streak <= '0;
            end else if (o_gnt_d) begin
                r_streak <= streak_inc(r_streak, STREAK_CAP);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between instruction fetch and data ports onto one memory port.
// Issues combinationally from IDLE, waits MEM_LAT cycles, then returns read data one cycle later.
module mem_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        busy
);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [LAT_W-1:0] r_lat_cnt;
    logic             r_owner_d;
    logic             r_is_store;

    logic             w_idle;
    logic             w_gnt_if;
    logic             w_gnt_d;
    logic             w_issue;
    logic             w_last;
    logic [N_REQ-1:0] w_capture;

    logic             r_rvalid [N_REQ];
    logic [31:0]      r_rdata  [N_REQ];

    assign w_idle = (r_state == ST_IDLE);

    mem_arbiter_prio #(
        .MAX_STREAK (MAX_STREAK)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .i_idle   (w_idle),
        .i_if_req (if_req),
        .i_d_req  (d_req),
        .o_gnt_if (w_gnt_if),
        .o_gnt_d  (w_gnt_d)
    );

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_last       = 1'b0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_d || w_gnt_if) begin
                    w_issue      = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Holding reset must silence the issue outputs even while requests are high
        if (rst && w_issue) begin
            mem_enable = 1'b1;
            if (w_gnt_d) begin
                d_gnt       = 1'b1;
                mem_wr      = d_we;
                mem_addr    = d_addr;
                mem_data_in = d_wdata;
            end else begin
                if_gnt   = 1'b1;
                mem_addr = if_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_lat_cnt  <= '0;
            r_owner_d  <= 1'b0;
            r_is_store <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_lat_cnt  <= LAT_W'(MEM_LAT - 1);
                r_owner_d  <= w_gnt_d;
                r_is_store <= w_gnt_d && d_we;
            end else if ((r_state == ST_WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
        end
    end

    assign w_capture[REQ_IF] = w_last && !r_owner_d;
    assign w_capture[REQ_D]  = w_last &&  r_owner_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cap
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_rvalid[gi] <= 1'b0;
                    r_rdata[gi]  <= '0;
                end else begin
                    r_rvalid[gi] <= w_capture[gi];
                    if (w_capture[gi]) begin
                        r_rdata[gi] <= ((gi == REQ_D) && r_is_store) ? 32'd0 : mem_data_out;
                    end
                end
            end
        end
    endgenerate

    assign if_rvalid = r_rvalid[REQ_IF];
    assign if_rdata  = r_rdata[REQ_IF];
    assign d_rvalid  = r_rvalid[REQ_D];
    assign d_rdata   = r_rdata[REQ_D];
    assign busy      = (r_state == ST_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, busy, mem_enable, mem_wr;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;

    logic        if_req_3, d_req_3, d_we_3;
    logic [31:0] if_addr_3, d_addr_3, d_wdata_3;
    logic        if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, busy_3, mem_enable_3, mem_wr_3;
    logic [31:0] if_rdata_3, d_rdata_3, mem_addr_3, mem_data_in_3, mem_data_out_3;

    mem_arbiter #(.MEM_LAT(1), .MAX_STREAK(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    mem_arbiter #(.MEM_LAT(3), .MAX_STREAK(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req_3), .if_addr(if_addr_3), .if_gnt(if_gnt_3), .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
        .d_req(d_req_3), .d_we(d_we_3), .d_addr(d_addr_3), .d_wdata(d_wdata_3),
        .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
        .mem_enable(mem_enable_3), .mem_wr(mem_wr_3), .mem_addr(mem_addr_3),
        .mem_data_in(mem_data_in_3), .mem_data_out(mem_data_out_3), .busy(busy_3)
    );

    // Memory models: registered read, data held until the next read
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] rd1, rd3;
    assign mem_data_out   = rd1;
    assign mem_data_out_3 = rd3;

    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_wr) mem1[mem_addr[9:2]] <= mem_data_in;
            else        rd1 <= mem1[mem_addr[9:2]];
        end
        if (mem_enable_3) begin
            if (mem_wr_3) mem3[mem_addr_3[9:2]] <= mem_data_in_3;
            else          rd3 <= mem3[mem_addr_3[9:2]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction monitors
    byte gseq[$];
    int  gcyc[$];
    int  g3cyc[$];
    int  r3cyc[$];
    int  r3dat[$];
    int  wr_cnt = 0;
    int  drv_cnt = 0;
    int  odd3 = 0;

    always @(negedge clk) begin
        if (if_gnt || d_gnt) begin
            gseq.push_back((if_gnt && d_gnt) ? 8'h58 : (d_gnt ? 8'h44 : 8'h46));
            gcyc.push_back(cyc);
            $display("txn dut1 cyc=%0d gnt if=%0b d=%0b addr=%h wr=%0b wdata=%h",
                     cyc, if_gnt, d_gnt, mem_addr, mem_wr, mem_data_in);
        end
        if (mem_enable && mem_wr) wr_cnt <= wr_cnt + 1;
        if (d_rvalid) begin
            drv_cnt <= drv_cnt + 1;
            $display("txn dut1 cyc=%0d d_rvalid rdata=%h", cyc, d_rdata);
        end
        if (if_rvalid) $display("txn dut1 cyc=%0d if_rvalid rdata=%h", cyc, if_rdata);
        if (if_gnt_3) begin
            g3cyc.push_back(cyc);
            $display("txn dut3 cyc=%0d if_gnt addr=%h busy=%0b", cyc, mem_addr_3, busy_3);
        end
        if (if_rvalid_3) begin
            r3cyc.push_back(cyc);
            r3dat.push_back(int'(if_rdata_3));
            $display("txn dut3 cyc=%0d if_rvalid rdata=%h", cyc, if_rdata_3);
        end
        if (d_gnt_3 || d_rvalid_3 || mem_wr_3 || (d_rdata_3 != 32'd0)) odd3 <= odd3 + 1;
    end

    int n_tot = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_pt();
        @(negedge clk);
    endtask

    task automatic wait_grants(input int n, input string tag);
        for (int k = 0; k < 40; k++) begin
            drive_pt();
            if (gseq.size() >= n) break;
        end
        check_val(tag, 32'(gseq.size() >= n), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        string exp_seq;
        int    base;

        for (int i = 0; i < 256; i++) begin
            mem1[i] = 32'hC0DE_0000 + 32'(i);
            mem3[i] = 32'hC0DE_0000 + 32'(i);
        end
        mem1[4] = 32'h0050_0093;
        rd1 = '0;
        rd3 = '0;

        // Reset with both requesters active: everything must stay quiet
        rst = 1'b0;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        if_addr = 32'h10; d_addr = 32'h100; d_wdata = 32'h1234_5678;
        if_req_3 = 1'b1; d_req_3 = 1'b0; d_we_3 = 1'b0;
        if_addr_3 = 32'h20; d_addr_3 = '0; d_wdata_3 = '0;
        sample_pt();
        check_val("rst_mem_enable", 32'(mem_enable), 32'd0);
        check_val("rst_if_gnt", 32'(if_gnt), 32'd0);
        check_val("rst_d_gnt", 32'(d_gnt), 32'd0);
        check_val("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_d_rdata", d_rdata, 32'd0);
        check_val("rst_if_gnt3", 32'(if_gnt_3), 32'd0);
        drive_pt();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; if_req_3 = 1'b0;
        d_wdata = 32'hFFFF_FFFF;
        drive_pt();
        rst = 1'b1;
        drive_pt();

        // Single fetch, MEM_LAT=1
        if_req = 1'b1; if_addr = 32'h10;
        sample_pt();
        check_val("f_gnt", 32'(if_gnt), 32'd1);
        check_val("f_mem_en", 32'(mem_enable), 32'd1);
        check_val("f_mem_addr", mem_addr, 32'h10);
        check_val("f_mem_wr", 32'(mem_wr), 32'd0);
        check_val("f_mem_din", mem_data_in, 32'd0);
        check_val("f_busy_issue", 32'(busy), 32'd0);
        drive_pt();
        if_req = 1'b0;
        sample_pt();
        check_val("f_busy_wait", 32'(busy), 32'd1);
        check_val("f_mem_en_wait", 32'(mem_enable), 32'd0);
        check_val("f_rvalid_c1", 32'(if_rvalid), 32'd0);
        drive_pt();
        sample_pt();
        check_val("f_rvalid_c2", 32'(if_rvalid), 32'd1);
        check_val("f_rdata", if_rdata, 32'h0050_0093);
        check_val("f_busy_rv", 32'(busy), 32'd0);
        drive_pt();
        sample_pt();
        check_val("f_rvalid_c3", 32'(if_rvalid), 32'd0);
        check_val("f_rdata_hold", if_rdata, 32'h0050_0093);

        // Store then back-to-back load from the store's rvalid cycle
        drive_pt();
        base = wr_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        sample_pt();
        check_val("st_gnt", 32'(d_gnt), 32'd1);
        check_val("st_mem_wr", 32'(mem_wr), 32'd1);
        check_val("st_mem_addr", mem_addr, 32'h100);
        check_val("st_mem_din", mem_data_in, 32'hDEAD_BEEF);
        drive_pt();
        d_req = 1'b0; d_we = 1'b0;
        sample_pt();
        check_val("st_rvalid_c1", 32'(d_rvalid), 32'd0);
        drive_pt();
        d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0;
        sample_pt();
        check_val("st_rvalid_c2", 32'(d_rvalid), 32'd1);
        check_val("st_rdata", d_rdata, 32'd0);
        check_val("ld_gnt_in_rv", 32'(d_gnt), 32'd1);
        check_val("ld_mem_wr", 32'(mem_wr), 32'd0);
        drive_pt();
        d_req = 1'b0;
        drive_pt();
        sample_pt();
        check_val("ld_rvalid", 32'(d_rvalid), 32'd1);
        check_val("ld_rdata", d_rdata, 32'hDEAD_BEEF);
        drive_pt();
        check_val("st_wr_once", 32'(wr_cnt - base), 32'd1);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'h0BAD_F00D;
        drive_pt();
        d_req = 1'b0; d_we = 1'b0;
        drive_pt();
        sample_pt();
        check_val("st2_rvalid", 32'(d_rvalid), 32'd1);
        check_val("st2_rdata", d_rdata, 32'd0);

        // Both held: data wins until the streak saturates
        drive_pt();
        gseq.delete(); gcyc.delete();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h10; d_addr = 32'h100;
        wait_grants(10, "seq_done");
        if_req = 1'b0; d_req = 1'b0;
        exp_seq = "DDDDFDDDDF";
        for (int i = 0; i < 10; i++)
            check_val($sformatf("seq%0d", i), 32'(gseq[i]), 32'(exp_seq[i]));
        check_val("seq_spacing", 32'(gcyc[1] - gcyc[0]), 32'd2);
        drive_pt(); drive_pt(); drive_pt();

        // Fetch backs off before saturation: streak clears
        gseq.delete(); gcyc.delete();
        if_req = 1'b1; d_req = 1'b1;
        wait_grants(2, "clr_a");
        if_req = 1'b0;
        wait_grants(3, "clr_b");
        if_req = 1'b1;
        wait_grants(8, "clr_c");
        if_req = 1'b0; d_req = 1'b0;
        exp_seq = "DDDDDDDF";
        for (int i = 0; i < 8; i++)
            check_val($sformatf("clr%0d", i), 32'(gseq[i]), 32'(exp_seq[i]));
        drive_pt(); drive_pt(); drive_pt();

        // MEM_LAT=3 back-to-back fetches
        g3cyc.delete(); r3cyc.delete(); r3dat.delete();
        if_req_3 = 1'b1; if_addr_3 = 32'h20;
        for (int k = 0; k < 40; k++) begin
            drive_pt();
            if (g3cyc.size() >= 3) break;
        end
        if_req_3 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            drive_pt();
            if (r3cyc.size() >= 3) break;
        end
        check_val("l3_gnt_cnt", 32'(g3cyc.size()), 32'd3);
        check_val("l3_rv_cnt", 32'(r3cyc.size()), 32'd3);
        check_val("l3_gnt1", 32'(g3cyc[1] - g3cyc[0]), 32'd4);
        check_val("l3_gnt2", 32'(g3cyc[2] - g3cyc[0]), 32'd8);
        check_val("l3_rv0", 32'(r3cyc[0] - g3cyc[0]), 32'd4);
        check_val("l3_rv1", 32'(r3cyc[1] - g3cyc[0]), 32'd8);
        check_val("l3_rv2", 32'(r3cyc[2] - g3cyc[0]), 32'd12);
        check_val("l3_rdata", 32'(r3dat[0]), 32'hC0DE_0008);
        check_val("l3_no_data", 32'(odd3), 32'd0);

        // Reset in the first WAIT cycle of a load
        drive_pt();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        sample_pt();
        check_val("ab_gnt", 32'(d_gnt), 32'd1);
        drive_pt();
        d_req = 1'b0;
        base = drv_cnt;
        #2;
        rst = 1'b0;
        if_req = 1'b1;
        #1;
        check_val("ab_busy", 32'(busy), 32'd0);
        check_val("ab_mem_en", 32'(mem_enable), 32'd0);
        check_val("ab_if_gnt", 32'(if_gnt), 32'd0);
        check_val("ab_d_rdata", d_rdata, 32'd0);
        check_val("ab_if_rdata", if_rdata, 32'd0);
        drive_pt(); drive_pt();
        rst = 1'b1; if_req = 1'b0;
        drive_pt(); drive_pt(); drive_pt(); drive_pt();
        check_val("ab_no_rvalid", 32'(drv_cnt - base), 32'd0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        sample_pt();
        check_val("ab_next_gnt", 32'(d_gnt), 32'd1);
        drive_pt();
        d_req = 1'b0;
        drive_pt();
        sample_pt();
        check_val("ab_next_rvalid", 32'(d_rvalid), 32'd1);
        check_val("ab_next_rdata", d_rdata, 32'hDEAD_BEEF);
        drive_pt();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
